// File: rtl/dt_result_scan.sv
// dt_result_scan: raster scan of the DT result map for peak, first peak address and counts.
// Build option: define DT_BORDER_SKIP_EN to scan only interior pixels (one-pixel border excluded).
module dt_result_scan #(
  parameter int AW    = 14,
  parameter int DW    = 8,
  parameter int IMG_W = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          res_rd,
  output logic [AW-1:0] res_addr,
  input  logic [DW-1:0] res_di,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] max_val,
  output logic [AW-1:0] max_addr,
  output logic [AW:0]   max_cnt,
  output logic [AW:0]   fg_cnt
);

  localparam int CW = $clog2(IMG_W);
`ifdef DT_BORDER_SKIP_EN
  localparam int FIRST_I = IMG_W + 1;
  localparam int LAST_I  = (1 << AW) - IMG_W - 2;
`else
  localparam int FIRST_I = 0;
  localparam int LAST_I  = (1 << AW) - 1;
`endif
  localparam int COLEND_I = IMG_W - 2;

  localparam logic [AW-1:0] FIRST  = AW'(FIRST_I);
  localparam logic [AW-1:0] LAST   = AW'(LAST_I);
  localparam logic [CW-1:0] COLEND = CW'(COLEND_I);
  localparam logic [AW-1:0] A1     = AW'(1);
  localparam logic [AW-1:0] A3     = AW'(3);
  localparam logic [AW:0]   C1     = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_DRAIN, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          vld_q;
  logic [AW-1:0] pa_q;

  logic [DW-1:0] max_q, max_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [AW:0]   mcnt_q, mcnt_d;
  logic [AW:0]   fg_q, fg_d;

  logic          accept;
  logic          last;
  logic [AW-1:0] step_a;

  assign accept = (state_q == S_IDLE) && start;
  assign last   = (addr_q == LAST);

  // Next raster address in the scan set
  always_comb begin
    step_a = addr_q + A1;
`ifdef DT_BORDER_SKIP_EN
    if (addr_q[CW-1:0] == COLEND) begin
      step_a = addr_q + A3;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    rd_d   = (state_d == S_READ);
    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_FIN);
    addr_d = addr_q;
    if (accept) begin
      addr_d = FIRST;
    end else if (state_q == S_READ && !last) begin
      addr_d = step_a;
    end
  end

  // Control output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= 1'b0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      addr_q <= addr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Read-return pipeline: address travels with the RAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      pa_q  <= '0;
    end else begin
      vld_q <= rd_q;
      pa_q  <= addr_q;
    end
  end

  // Accumulator update for each returned datum
  always_comb begin
    max_d   = max_q;
    maddr_d = maddr_q;
    mcnt_d  = mcnt_q;
    fg_d    = fg_q;
    if (accept) begin
      max_d   = '0;
      maddr_d = '0;
      mcnt_d  = '0;
      fg_d    = '0;
    end else if (vld_q) begin
      if (res_di > max_q) begin
        max_d   = res_di;
        maddr_d = pa_q;
        mcnt_d  = C1;
      end else if (res_di == max_q && res_di != '0) begin
        mcnt_d = mcnt_q + C1;
      end
      if (res_di != '0) begin
        fg_d = fg_q + C1;
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q   <= '0;
      maddr_q <= '0;
      mcnt_q  <= '0;
      fg_q    <= '0;
    end else begin
      max_q   <= max_d;
      maddr_q <= maddr_d;
      mcnt_q  <= mcnt_d;
      fg_q    <= fg_d;
    end
  end

  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign max_val  = max_q;
  assign max_addr = maddr_q;
  assign max_cnt  = mcnt_q;
  assign fg_cnt   = fg_q;

endmodule
